// File: rtl/enemy_unit.sv
// Single enemy combatant for the lane battle: idle, deploy with a rotating type,
// march toward the friendly front, attack when blocked, and take damage until death.
module enemy_unit #(
   parameter int unsigned START_POS   = 511,
   parameter int unsigned SPAWN_DELAY = 1,
   parameter int unsigned HP1         = 200,
   parameter int unsigned HP2         = 120,
   parameter int unsigned HP3         = 250,
   parameter int unsigned SPD1        = 1,
   parameter int unsigned SPD2        = 2,
   parameter int unsigned SPD3        = 1,
   parameter int unsigned ATK1        = 10,
   parameter int unsigned ATK2        = 20,
   parameter int unsigned ATK3        = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       moveSCEN,
   input  logic       damageSCEN,
   input  logic [7:0] damageIn,
   input  logic [8:0] unitFront,
   output logic [8:0] position,
   output logic [7:0] damageOut,
   output logic [1:0] enemyType,
   output logic       q_I,
   output logic       q_Deploy1,
   output logic       q_Deploy2,
   output logic       q_Deploy3,
   output logic       q_Alive,
   output logic [7:0] health
);

   localparam int unsigned      CNT_W     = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_DELAY - 1);
   localparam logic [8:0]       POS_SPAWN = 9'(START_POS);

   typedef enum logic [2:0] {
      ST_I       = 3'd0,
      ST_DEPLOY1 = 3'd1,
      ST_DEPLOY2 = 3'd2,
      ST_DEPLOY3 = 3'd3,
      ST_ALIVE   = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [8:0]       position_reg, position_next;
   logic [7:0]       health_reg, health_next;
   logic [7:0]       damage_out_reg, damage_out_next;
   logic [1:0]       enemy_type_reg, enemy_type_next;
   logic [1:0]       sel_reg, sel_next;
   logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;

   logic [8:0]       speed;
   logic [8:0]       gap;

   function automatic logic [7:0] hp_of(input logic [1:0] t);
      case (t)
         2'd1:    hp_of = 8'(HP1);
         2'd2:    hp_of = 8'(HP2);
         2'd3:    hp_of = 8'(HP3);
         default: hp_of = 8'd0;
      endcase
   endfunction

   function automatic logic [8:0] spd_of(input logic [1:0] t);
      case (t)
         2'd1:    spd_of = 9'(SPD1);
         2'd2:    spd_of = 9'(SPD2);
         2'd3:    spd_of = 9'(SPD3);
         default: spd_of = 9'd0;
      endcase
   endfunction

   function automatic logic [7:0] atk_of(input logic [1:0] t);
      case (t)
         2'd1:    atk_of = 8'(ATK1);
         2'd2:    atk_of = 8'(ATK2);
         2'd3:    atk_of = 8'(ATK3);
         default: atk_of = 8'd0;
      endcase
   endfunction

   assign speed = spd_of(enemy_type_reg);
   // Only meaningful when position_reg > unitFront, so it never wraps where it is used.
   assign gap   = position_reg - unitFront;

   always_comb begin
      state_next      = state_reg;
      position_next   = position_reg;
      health_next     = health_reg;
      damage_out_next = damage_out_reg;
      enemy_type_next = enemy_type_reg;
      sel_next        = sel_reg;
      idle_cnt_next   = idle_cnt_reg;

      case (state_reg)
         ST_I: begin
            position_next   = POS_SPAWN;
            health_next     = 8'd0;
            damage_out_next = 8'd0;
            enemy_type_next = 2'd0;
            if (idle_cnt_reg == CNT_LAST) begin
               idle_cnt_next = '0;
               health_next   = hp_of(sel_reg);
               sel_next      = (sel_reg == 2'd3) ? 2'd1 : sel_reg + 2'd1;
               case (sel_reg)
                  2'd2:    state_next = ST_DEPLOY2;
                  2'd3:    state_next = ST_DEPLOY3;
                  default: state_next = ST_DEPLOY1;
               endcase
            end else begin
               idle_cnt_next = idle_cnt_reg + CNT_W'(1);
            end
         end

         ST_DEPLOY1, ST_DEPLOY2, ST_DEPLOY3: begin
            position_next   = POS_SPAWN;
            damage_out_next = 8'd0;
            state_next      = ST_ALIVE;
            enemy_type_next = 2'(state_reg);
         end

         ST_ALIVE: begin
            damage_out_next = 8'd0;
            if (moveSCEN) begin
               if (position_reg > unitFront) begin
                  position_next = (gap > speed) ? position_reg - speed : unitFront;
               end else begin
                  damage_out_next = atk_of(enemy_type_reg);
               end
            end
            if (damageSCEN && (damageIn != 8'd0)) begin
               if (damageIn >= health_reg) begin
                  // Death wins over whatever the move evaluation produced.
                  state_next      = ST_I;
                  health_next     = 8'd0;
                  position_next   = POS_SPAWN;
                  enemy_type_next = 2'd0;
                  damage_out_next = 8'd0;
                  idle_cnt_next   = '0;
               end else begin
                  health_next = health_reg - damageIn;
               end
            end
         end

         default: begin
            state_next = ST_I;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_I;
         position_reg   <= POS_SPAWN;
         health_reg     <= 8'd0;
         damage_out_reg <= 8'd0;
         enemy_type_reg <= 2'd0;
         sel_reg        <= 2'd1;
         idle_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         position_reg   <= position_next;
         health_reg     <= health_next;
         damage_out_reg <= damage_out_next;
         enemy_type_reg <= enemy_type_next;
         sel_reg        <= sel_next;
         idle_cnt_reg   <= idle_cnt_next;
      end
   end

   assign position  = position_reg;
   assign health    = health_reg;
   assign damageOut = damage_out_reg;
   assign enemyType = enemy_type_reg;
   assign q_I       = (state_reg == ST_I);
   assign q_Deploy1 = (state_reg == ST_DEPLOY1);
   assign q_Deploy2 = (state_reg == ST_DEPLOY2);
   assign q_Deploy3 = (state_reg == ST_DEPLOY3);
   assign q_Alive   = (state_reg == ST_ALIVE);

endmodule

// File: tb/tb_enemy_unit.sv
// Bench for enemy_unit: directed lifecycle walk-through followed by randomized
// move/damage traffic checked against a lifecycle model kept in the bench.
module tb_enemy_unit;

   localparam int SPAWN_DELAY = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       moveSCEN;
   logic       damageSCEN;
   logic [7:0] damageIn;
   logic [8:0] unitFront;
   logic [8:0] position;
   logic [7:0] damageOut;
   logic [1:0] enemyType;
   logic       q_I, q_Deploy1, q_Deploy2, q_Deploy3, q_Alive;
   logic [7:0] health;

   int cmp_cnt = 0;
   int err_cnt = 0;

   // Model: phase 0 = idle, 1..3 = deploying that type, 4 = alive.
   int m_phase, m_pos, m_hp, m_dmg, m_type, m_sel, m_idle;
   int hp_tab[4]  = '{0, 200, 120, 250};
   int spd_tab[4] = '{0, 1, 2, 1};
   int atk_tab[4] = '{0, 10, 20, 40};

   enemy_unit dut (
      .clk        (clk),
      .reset      (reset),
      .moveSCEN   (moveSCEN),
      .damageSCEN (damageSCEN),
      .damageIn   (damageIn),
      .unitFront  (unitFront),
      .position   (position),
      .damageOut  (damageOut),
      .enemyType  (enemyType),
      .q_I        (q_I),
      .q_Deploy1  (q_Deploy1),
      .q_Deploy2  (q_Deploy2),
      .q_Deploy3  (q_Deploy3),
      .q_Alive    (q_Alive),
      .health     (health)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_phase = 0; m_pos = 511; m_hp = 0; m_dmg = 0; m_type = 0; m_sel = 1; m_idle = 0;
   endtask

   task automatic model_step();
      int front, spd;
      front = int'(unitFront);
      case (m_phase)
         0: begin
            m_idle++;
            if (m_idle >= SPAWN_DELAY) begin
               m_idle  = 0;
               m_phase = m_sel;
               m_hp    = hp_tab[m_sel];
               m_sel   = (m_sel % 3) + 1;
            end
         end
         1, 2, 3: begin
            m_type  = m_phase;
            m_phase = 4;
         end
         default: begin
            spd   = spd_tab[m_type];
            m_dmg = 0;
            if (moveSCEN) begin
               if (m_pos > front) m_pos = (m_pos - spd > front) ? m_pos - spd : front;
               else               m_dmg = atk_tab[m_type];
            end
            if (damageSCEN && damageIn > 0) begin
               if (int'(damageIn) >= m_hp) begin
                  m_phase = 0; m_hp = 0; m_pos = 511; m_type = 0; m_dmg = 0; m_idle = 0;
               end else begin
                  m_hp = m_hp - int'(damageIn);
               end
            end
         end
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      cmp_cnt++;
      assert (obs === 32'(exp))
      else begin
         err_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/position"},  position,  m_pos);
      check({tag, "/health"},    health,    m_hp);
      check({tag, "/damageOut"}, damageOut, m_dmg);
      check({tag, "/enemyType"}, enemyType, m_type);
      check({tag, "/q_I"},       q_I,       int'(m_phase == 0));
      check({tag, "/q_Deploy1"}, q_Deploy1, int'(m_phase == 1));
      check({tag, "/q_Deploy2"}, q_Deploy2, int'(m_phase == 2));
      check({tag, "/q_Deploy3"}, q_Deploy3, int'(m_phase == 3));
      check({tag, "/q_Alive"},   q_Alive,   int'(m_phase == 4));
      check({tag, "/onehot"},    32'($countones({q_I, q_Deploy1, q_Deploy2, q_Deploy3, q_Alive})), 1);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b0; moveSCEN = 1'b0; damageSCEN = 1'b0; damageIn = 8'd0; unitFront = 9'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      check("reset_pos", position, 511);
      reset = 1'b1;

      step("deploy1");
      check("deploy1_flag", q_Deploy1, 1);
      check("deploy1_hp", health, 200);
      check("deploy1_type", enemyType, 0);
      step("alive1");
      check("alive1_type", enemyType, 1);

      unitFront = 9'd0; moveSCEN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("march1");
         check("march1_pos", position, 510 - i);
      end
      unitFront = 9'd508;
      step("blocked1");
      check("blocked1_pos", position, 508);
      check("blocked1_atk", damageOut, 10);
      moveSCEN = 1'b0;
      step("nomove1");
      check("nomove1_atk", damageOut, 0);

      damageSCEN = 1'b1; damageIn = 8'd128;
      step("hit1");
      check("hit1_hp", health, 72);
      step("kill1");
      check("kill1_flag", q_I, 1);
      check("kill1_pos", position, 511);
      damageSCEN = 1'b0; damageIn = 8'd0;

      step("deploy2");
      check("deploy2_hp", health, 120);
      step("alive2");
      unitFront = 9'd0; moveSCEN = 1'b1;
      step("march2");
      check("march2_pos", position, 509);

      // Asynchronous reset mid-march, sampled between clock edges.
      reset = 1'b0;
      #2;
      model_reset();
      check_all("async_rst");
      check("async_rst_flag", q_I, 1);
      moveSCEN = 1'b0;
      #2 reset = 1'b1;
      step("redeploy1");
      check("redeploy1_flag", q_Deploy1, 1);
      step("realive1");

      // Exact-health kill while moving: death must override the move.
      damageSCEN = 1'b1; damageIn = 8'd200; moveSCEN = 1'b1; unitFront = 9'd0;
      step("exact_kill");
      check("exact_kill_pos", position, 511);
      damageSCEN = 1'b0; moveSCEN = 1'b0;
      step("deploy2b");
      step("alive2b");
      damageSCEN = 1'b1; damageIn = 8'd0;
      step("zero_dmg");
      check("zero_dmg_hp", health, 120);
      damageSCEN = 1'b0;
      unitFront = 9'd510; moveSCEN = 1'b1;
      step("clamp");
      check("clamp_pos", position, 510);
      step("blocked2");
      check("blocked2_atk", damageOut, 20);

      for (int i = 0; i < 800; i++) begin
         moveSCEN   = 1'($urandom_range(0, 1));
         damageSCEN = ($urandom_range(0, 3) == 0);
         damageIn   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
         if ($urandom_range(0, 7) == 0) unitFront = 9'($urandom_range(0, 511));
         if (i % 250 == 125) begin
            reset = 1'b0;
            #2;
            model_reset();
            check_all("rand_rst");
            #2 reset = 1'b1;
         end
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/enemy_unit.md
Name: enemy_unit

Overview:
Single enemy combatant for the lane-battle game. Holds one enemy's lifecycle: idle, deploy with a rotating type, then march toward the friendly front, attack when blocked, and take damage until death. On death it returns to idle and respawns as the next type. Driven by the game scheduler's move and damage scan-enables; sits alongside the friendly-unit blocks that supply the front position.

Parameters:
START_POS, 511, spawn position (far end of the 9-bit field)
SPAWN_DELAY, 1, cycles spent in idle before deploying (minimum 1)
HP1/HP2/HP3, 200/120/250, starting health per type
SPD1/SPD2/SPD3, 1/2/1, positions moved per move cycle per type
ATK1/ATK2/ATK3, 10/20/40, damage emitted per attack cycle per type

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
moveSCEN  in  1  move/attack scan enable for this cycle
damageSCEN  in  1  apply damageIn this cycle
damageIn  in  8  incoming damage, unsigned
unitFront  in  9  position of the front-most friendly unit
position  out  9  current enemy position, registered
damageOut  out  8  damage dealt this cycle, registered
enemyType  out  2  0 = none, 1..3 = active type
q_I, q_Deploy1, q_Deploy2, q_Deploy3, q_Alive  out  1 each  one-hot state flags
health  out  8  current health, registered

Behaviour:
- Reset (reset=0, asynchronous): state I, position=START_POS, health=0, damageOut=0, enemyType=0, next-type selector=1, idle counter=0.
- State flags are one-hot and always exactly one is high.
- I: position=START_POS, health=0, damageOut=0, enemyType=0. After SPAWN_DELAY cycles, go to Deploy{sel}; then sel rotates 1->2->3->1.
- DeployN (1 cycle): load health=HPn, position=START_POS; enemyType stays 0; damageOut=0. Next edge go to Alive and set enemyType=n.
- Alive, moveSCEN=1:
  - if position > unitFront: position <= max(position - SPDn, unitFront), computed without 9-bit underflow; damageOut <= 0.
  - else (blocked, position <= unitFront): position holds; damageOut <= ATKn.
- Alive, moveSCEN=0: position holds; damageOut <= 0.
- Alive, damageSCEN=1:
  - if damageIn >= health: health <= 0 and the next state is I. In that cycle position, enemyType and damageOut also take their I values.
  - else health <= health - damageIn.
  - damageIn=0 has no effect.
- Move and damage in the same cycle are both evaluated. Death overrides the move result.
- Inputs are ignored outside Alive.
- Asynchronous reset asserted in any state, mid-march included, forces the reset values immediately.

Test Plan:
- Reset low then high -> q_I=1, position=511, health=0, enemyType=0, damageOut=0.
- One cycle after idle -> q_Deploy1=1, health=200, enemyType=0. Next edge -> q_Alive=1, enemyType=1.
- Alive type 1, unitFront=0, moveSCEN=1 for 3 cycles -> position 510, 509, 508; damageOut=0.
- At position 508: set unitFront=508 -> position holds at 508, damageOut=10 on the next edge. Set moveSCEN=0 -> damageOut=0.
- damageSCEN=1, damageIn=128 -> health 200->72. Next cycle 128 -> health=0, q_I=1, enemyType=0, position=511.
  - Respawn then goes to q_Deploy2: health=120, speed 2 (511->509 with unitFront=0).
  - Pull reset low while Alive -> immediate return to q_I; the next spawn is type 1.
